pifo_reg_param: RTL and testbench
=================================

# pifo_reg_param

Parametrised register-array PIFO (push-in, first-out) scheduler queue, the next generation of the team's fixed 16-entry PIFO. Holds up to DEPTH (rank, meta) entries sorted ascending by rank. It exposes the minimum-rank entry for dequeue and the maximum-rank entry for inspection. It adds same-cycle insert+remove, FIFO tie-breaking among equal ranks, an almost-full flag and an explicit drop/push-out report port. It sits between the packet classifier and the egress arbiter.

## Interface
- DEPTH, 16, number of entries (≥1)
- RANK_W, 16, rank width (unsigned)
- META_W, 12, metadata width
- AF_THRESH, DEPTH-2, almost_full asserts when num_entries ≥ AF_THRESH
- CNT_W (localparam), $clog2(DEPTH+1), occupancy width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- insert  in  1  push request, qualified on clk
- rank_in  in  RANK_W  rank of pushed entry
- meta_in  in  META_W  metadata of pushed entry
- remove  in  1  pop-minimum request
- valid_out  out  1  head entry present (= !empty)
- rank_out / meta_out  out  RANK_W / META_W  minimum-rank entry; 0 when empty
- max_valid_out  out  1  = !empty
- max_rank_out / max_meta_out  out  RANK_W / META_W  maximum-rank entry (slot num_entries-1); 0 when empty
- num_entries  out  CNT_W  occupancy
- empty / full / almost_full  out  1  status
- drop_valid  out  1  one-cycle pulse: an entry was discarded
- drop_rank / drop_meta  out  RANK_W / META_W  discarded entry, valid with drop_valid

## Operation
- Storage: DEPTH slots, slot 0 = minimum. Valid slots are 0..num_entries-1. Order is ascending rank. Equal ranks keep arrival order: a new entry goes after all existing entries of equal rank.
- Head/max/status outputs are combinational from state registers. drop_* are registered.
- remove, not empty: slot 0 leaves, remaining slots shift down, num_entries-1.
- remove when empty: ignored, no error indication.
- insert, not full: entry placed at its sorted position, higher slots shift up, num_entries+1.
- insert+remove same cycle, not empty: the old head is removed and the new entry inserted into the remainder. num_entries unchanged. Accepted even when full, with no drop. If rank_in is below every remaining rank, the new entry becomes head.
- insert+remove when empty: remove ignored, insert performed, num_entries=1.
- insert when full without remove: governed by the push-out policy (Configuration). Exactly one entry is discarded and reported on drop_*.
- num_entries never exceeds DEPTH and never underflows.

## Timing
- All state updates on rising clk. Inputs are sampled at that edge. Outputs reflect the new state after the edge (zero-cycle combinational visibility of state).
- Inserted entry is visible on rank_out at the earliest in the cycle after the insert edge. There is no same-cycle bypass.
- drop_valid is high for exactly the one cycle following the edge that caused the drop. drop_rank/drop_meta are held until the next drop.
- Reset (async assert, released synchronously by the environment): num_entries=0, empty=1, full=0, almost_full=(AF_THRESH==0), valid_out=0, max_valid_out=0, rank_out/meta_out/max_*=0, drop_valid=0, drop_rank/drop_meta=0. All slot contents are cleared.
- Reset mid-operation discards all entries immediately. No drop is reported.

## Configuration
- PIFO_PUSHOUT_EN defined: on insert when full without remove:
  - if rank_in < max_rank_out (strict), the current max entry is evicted and reported on drop_*, and the new entry is inserted sorted;
  - otherwise (rank_in ≥ max) the incoming entry is dropped and reported.
  - num_entries stays DEPTH in both cases.
- PIFO_PUSHOUT_EN undefined: insert when full without remove always drops the incoming entry (tail-drop) and reports it on drop_*. Stored state is unchanged.

## Test plan
- Reset then insert ranks 30,10,20 (meta 1,2,3) -> rank_out=10/meta 2, max_rank_out=30, num_entries=3. Three removes yield 10,20,30, then empty=1 and rank_out=0.
- Insert rank 5 three times (meta 7,8,9) -> removes return meta 7,8,9 in order (FIFO tie-break).
- Fill DEPTH=16 with ranks 100..115, then insert+remove rank 50 together -> num_entries stays 16, head=50, no drop_valid; almost_full=1 from occupancy 14.
- Full with ranks 100..115, insert rank 50 alone. With PIFO_PUSHOUT_EN: drop_rank=115 for one cycle, head=50, max=114. Without it: drop_rank=50, contents unchanged.
- Full, insert rank 200 alone -> drop_rank=200 in both configurations, state unchanged.
- insert+remove on empty -> num_entries=1. Remove on empty -> no change. Assert rst with 5 entries -> num_entries=0 and all outputs at reset values without waiting for a clk edge.

Source files
------------

// File: rtl/pifo_reg_param.sv
// pifo_reg_param: register-array PIFO scheduler queue.
// Holds up to DEPTH (rank, meta) entries sorted ascending by rank, with equal
// ranks kept in arrival order. Slot 0 is the minimum (head); slot
// num_entries-1 is the maximum. Supports same-cycle insert+remove.
//
// Optional feature macro: PIFO_PUSHOUT_EN
//   defined   : insert when full (no remove) evicts the current max entry if
//               rank_in < max rank, otherwise drops the incoming entry.
//   undefined : insert when full (no remove) always drops the incoming entry.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   insert/rank_in/meta_in   push request and entry
//   remove                   pop-minimum request (ignored when empty)
//   valid_out/rank_out/meta_out          head entry (0 when empty)
//   max_valid_out/max_rank_out/max_meta_out  maximum entry (0 when empty)
//   num_entries, empty, full, almost_full    occupancy status
//   drop_valid/drop_rank/drop_meta       registered report of a discarded entry
module pifo_reg_param #(
  parameter int DEPTH     = 16,
  parameter int RANK_W    = 16,
  parameter int META_W    = 12,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              insert,
  input  logic [RANK_W-1:0] rank_in,
  input  logic [META_W-1:0] meta_in,
  input  logic              remove,
  output logic              valid_out,
  output logic [RANK_W-1:0] rank_out,
  output logic [META_W-1:0] meta_out,
  output logic              max_valid_out,
  output logic [RANK_W-1:0] max_rank_out,
  output logic [META_W-1:0] max_meta_out,
  output logic [CNT_W-1:0]  num_entries,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              drop_valid,
  output logic [RANK_W-1:0] drop_rank,
  output logic [META_W-1:0] drop_meta
);

`ifdef PIFO_PUSHOUT_EN
  localparam bit PUSHOUT = 1'b1;
`else
  localparam bit PUSHOUT = 1'b0;
`endif

  logic [DEPTH-1:0][RANK_W-1:0] r_rank;
  logic [DEPTH-1:0][META_W-1:0] r_meta;
  logic [CNT_W-1:0]             r_cnt;
  logic                         r_drop_valid;
  logic [RANK_W-1:0]            r_drop_rank;
  logic [META_W-1:0]            r_drop_meta;

  logic [DEPTH-1:0][RANK_W-1:0] w_base_rank, w_nxt_rank;
  logic [DEPTH-1:0][META_W-1:0] w_base_meta, w_nxt_meta;
  logic [CNT_W-1:0]             w_base_cnt, w_nxt_cnt, w_pos;
  logic [RANK_W-1:0]            w_max_rank;
  logic [META_W-1:0]            w_max_meta;
  logic                         w_empty, w_full, w_do_rem, w_do_ins;
  logic                         w_evict, w_tdrop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(DEPTH));

  // Max entry lives at slot r_cnt-1; select by compare to avoid a
  // variable-index width mismatch.
  always_comb begin
    w_max_rank = '0;
    w_max_meta = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i + 1) == r_cnt) begin
        w_max_rank = r_rank[i];
        w_max_meta = r_meta[i];
      end
    end
  end

  always_comb begin
    w_do_rem = remove && !w_empty;
    // Evict-max and tail-drop only apply when nothing is leaving this cycle.
    w_evict  = PUSHOUT && insert && w_full && !w_do_rem && (rank_in < w_max_rank);
    w_tdrop  = insert && w_full && !w_do_rem && !w_evict;
    w_do_ins = insert && !w_tdrop;

    // Base = state after the optional head removal.
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_base_rank[i] = w_do_rem ? r_rank[i+1] : r_rank[i];
      w_base_meta[i] = w_do_rem ? r_meta[i+1] : r_meta[i];
    end
    w_base_rank[DEPTH-1] = w_do_rem ? '0 : r_rank[DEPTH-1];
    w_base_meta[DEPTH-1] = w_do_rem ? '0 : r_meta[DEPTH-1];

    // On eviction the max slot is treated as gone; the upward shift during
    // insertion overwrites it.
    if (w_do_rem)     w_base_cnt = r_cnt - 1'b1;
    else if (w_evict) w_base_cnt = CNT_W'(DEPTH - 1);
    else              w_base_cnt = r_cnt;

    // Sorted position = number of valid entries with rank <= rank_in, which
    // places the new entry after all equal ranks.
    w_pos = '0;
    for (int i = 0; i < DEPTH; i++)
      if (CNT_W'(i) < w_base_cnt && w_base_rank[i] <= rank_in) w_pos = w_pos + 1'b1;

    w_nxt_rank[0] = (w_do_ins && w_pos == '0) ? rank_in : w_base_rank[0];
    w_nxt_meta[0] = (w_do_ins && w_pos == '0) ? meta_in : w_base_meta[0];
    for (int i = 1; i < DEPTH; i++) begin
      if (!w_do_ins || CNT_W'(i) < w_pos) begin
        w_nxt_rank[i] = w_base_rank[i];
        w_nxt_meta[i] = w_base_meta[i];
      end else if (CNT_W'(i) == w_pos) begin
        w_nxt_rank[i] = rank_in;
        w_nxt_meta[i] = meta_in;
      end else begin
        w_nxt_rank[i] = w_base_rank[i-1];
        w_nxt_meta[i] = w_base_meta[i-1];
      end
    end

    w_nxt_cnt = w_do_ins ? w_base_cnt + 1'b1 : w_base_cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rank       <= '0;
      r_meta       <= '0;
      r_cnt        <= '0;
      r_drop_valid <= 1'b0;
      r_drop_rank  <= '0;
      r_drop_meta  <= '0;
    end else begin
      r_rank       <= w_nxt_rank;
      r_meta       <= w_nxt_meta;
      r_cnt        <= w_nxt_cnt;
      r_drop_valid <= w_evict || w_tdrop;
      if (w_evict) begin
        r_drop_rank <= w_max_rank;
        r_drop_meta <= w_max_meta;
      end else if (w_tdrop) begin
        r_drop_rank <= rank_in;
        r_drop_meta <= meta_in;
      end
    end
  end

  assign valid_out     = !w_empty;
  assign rank_out      = w_empty ? '0 : r_rank[0];
  assign meta_out      = w_empty ? '0 : r_meta[0];
  assign max_valid_out = !w_empty;
  assign max_rank_out  = w_max_rank;
  assign max_meta_out  = w_max_meta;
  assign num_entries   = r_cnt;
  assign empty         = w_empty;
  assign full          = w_full;
  assign almost_full   = (int'(r_cnt) >= AF_THRESH);
  assign drop_valid    = r_drop_valid;
  assign drop_rank     = r_drop_rank;
  assign drop_meta     = r_drop_meta;

endmodule

// File: tb/tb_pifo_reg_param.sv
module tb_pifo_reg_param;
  localparam int DEPTH = 16, RANK_W = 16, META_W = 12, AF = DEPTH - 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 0, rst = 1, insert = 0, remove = 0;
  logic [RANK_W-1:0] rank_in = '0;
  logic [META_W-1:0] meta_in = '0;
  logic valid_out, max_valid_out, empty, full, almost_full, drop_valid;
  logic [RANK_W-1:0] rank_out, max_rank_out, drop_rank;
  logic [META_W-1:0] meta_out, max_meta_out, drop_meta;
  logic [CNT_W-1:0] num_entries;

  pifo_reg_param #(.DEPTH(DEPTH), .RANK_W(RANK_W), .META_W(META_W)) dut (
    .clk(clk), .rst(rst), .insert(insert), .rank_in(rank_in), .meta_in(meta_in),
    .remove(remove), .valid_out(valid_out), .rank_out(rank_out), .meta_out(meta_out),
    .max_valid_out(max_valid_out), .max_rank_out(max_rank_out), .max_meta_out(max_meta_out),
    .num_entries(num_entries), .empty(empty), .full(full), .almost_full(almost_full),
    .drop_valid(drop_valid), .drop_rank(drop_rank), .drop_meta(drop_meta));

  always #5 clk = ~clk;

  typedef struct { int r; int m; } ent_t;
  ent_t q[$];
  int   m_dv, m_dr, m_dm;
  int   total = 0, bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: sorted list semantics straight from the queue rules.
  function automatic void model_step(input bit ins, input int r, input int m, input bit rem);
    int idx;
    ent_t e;
    m_dv = 0;
    if (rem && q.size() > 0) void'(q.pop_front());
    if (ins) begin
      e.r = r; e.m = m;
      if (q.size() >= DEPTH) begin
`ifdef PIFO_PUSHOUT_EN
        if (r < q[$].r) begin
          ent_t d;
          d = q.pop_back();
          m_dv = 1; m_dr = d.r; m_dm = d.m;
        end else begin
          m_dv = 1; m_dr = r; m_dm = m;
          return;
        end
`else
        m_dv = 1; m_dr = r; m_dm = m;
        return;
`endif
      end
      idx = 0;
      while (idx < q.size() && q[idx].r <= r) idx++;
      q.insert(idx, e);
    end
  endfunction

  task automatic model_check(input string tag);
    int n;
    n = q.size();
    chk({tag, ".cnt"},   int'(num_entries), n);
    chk({tag, ".valid"}, int'(valid_out) + 2*int'(max_valid_out) + 4*int'(empty), n > 0 ? 3 : 4);
    chk({tag, ".full"},  int'(full), n == DEPTH ? 1 : 0);
    chk({tag, ".af"},    int'(almost_full), n >= AF ? 1 : 0);
    chk({tag, ".head"},  int'(rank_out) * 4096 + int'(meta_out), n > 0 ? q[0].r * 4096 + q[0].m : 0);
    chk({tag, ".max"},   int'(max_rank_out) * 4096 + int'(max_meta_out), n > 0 ? q[$].r * 4096 + q[$].m : 0);
    chk({tag, ".dv"},    int'(drop_valid), m_dv);
    chk({tag, ".drop"},  int'(drop_rank) * 4096 + int'(drop_meta), m_dr * 4096 + m_dm);
  endtask

  task automatic step(input bit ins, input int r, input int m, input bit rem, input string tag);
    insert = ins; rank_in = RANK_W'(r); meta_in = META_W'(m); remove = rem;
    @(posedge clk); #1;
    insert = 0; remove = 0;
    model_step(ins, r, m, rem);
    model_check(tag);
  endtask

  task automatic do_reset();
    insert = 0; remove = 0;
    rst = 1;
    #1;
    q.delete(); m_dv = 0; m_dr = 0; m_dm = 0;
    model_check("rst_async");
    @(posedge clk); #1;
    rst = 0;
  endtask

  typedef struct { bit ins; int r; int m; bit rem; int er; int em; int ec; } vec_t;
  vec_t tv[$];

  initial begin
    // Test-plan sequences with hand-derived expectations.
    tv = '{
      '{1, 30, 1, 0, 30, 1, 1}, '{1, 10, 2, 0, 10, 2, 2}, '{1, 20, 3, 0, 10, 2, 3},
      '{0, 0, 0, 1, 20, 3, 2},  '{0, 0, 0, 1, 30, 1, 1},  '{0, 0, 0, 1, 0, 0, 0},
      '{0, 0, 0, 1, 0, 0, 0},   // remove on empty: no change
      '{1, 5, 7, 0, 5, 7, 1},   '{1, 5, 8, 0, 5, 7, 2},   '{1, 5, 9, 0, 5, 7, 3},
      '{0, 0, 0, 1, 5, 8, 2},   '{0, 0, 0, 1, 5, 9, 1},   '{0, 0, 0, 1, 0, 0, 0},
      '{1, 40, 4, 1, 40, 4, 1}, // insert+remove on empty
      '{0, 0, 0, 1, 0, 0, 0}
    };
    m_dv = 0; m_dr = 0; m_dm = 0;
    do_reset();
    chk("reset.max_after_edge", int'(max_rank_out), 0);

    foreach (tv[i]) begin
      step(tv[i].ins, tv[i].r, tv[i].m, tv[i].rem, $sformatf("tv%0d", i));
      chk($sformatf("tv%0d.rank", i), int'(rank_out), tv[i].er);
      chk($sformatf("tv%0d.meta", i), int'(meta_out), tv[i].em);
      chk($sformatf("tv%0d.cnt", i),  int'(num_entries), tv[i].ec);
    end

    // Fill with 100..115, almost_full from occupancy 14.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 100 + i, i, 0, "fill");
      chk("fill.af_const", int'(almost_full), (i + 1) >= 14 ? 1 : 0);
    end
    step(1, 50, 77, 1, "ins_rem_full");
    chk("ins_rem_full.head", int'(rank_out), 50);
    chk("ins_rem_full.cnt", int'(num_entries), 16);
    chk("ins_rem_full.nodrop", int'(drop_valid), 0);

    // Full with 100..115, insert 50 alone.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 100 + i, i, 0, "fill2");
    step(1, 50, 33, 0, "push_full");
    chk("push_full.dv", int'(drop_valid), 1);
`ifdef PIFO_PUSHOUT_EN
    chk("push_full.drop", int'(drop_rank), 115);
    chk("push_full.head", int'(rank_out), 50);
    chk("push_full.max",  int'(max_rank_out), 114);
`else
    chk("push_full.drop", int'(drop_rank), 50);
    chk("push_full.head", int'(rank_out), 100);
    chk("push_full.max",  int'(max_rank_out), 115);
`endif
    step(0, 0, 0, 0, "drop_pulse_end");
    chk("drop_pulse_end.dv", int'(drop_valid), 0);
    step(1, 200, 5, 0, "push_200");
    chk("push_200.drop", int'(drop_rank), 200);
    chk("push_200.cnt", int'(num_entries), 16);

    // Async reset mid-operation with 5 entries.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 9 - i, i, 0, "five");
    @(negedge clk);
    rst = 1;
    #1;
    q.delete(); m_dv = 0; m_dr = 0; m_dm = 0;
    model_check("async_rst");
    chk("async_rst.cnt0", int'(num_entries), 0);
    @(posedge clk); #1;
    rst = 0;

    // Randomised traffic against the reference; small rank range forces ties.
    for (int n = 0; n < 3000; n++) begin
      bit ins, rem;
      int mode;
      mode = (n / 300) % 3;  // phases biased to fill, drain, mixed
      ins = ($urandom_range(0, 99) < (mode == 0 ? 80 : mode == 1 ? 25 : 55));
      rem = ($urandom_range(0, 99) < (mode == 0 ? 20 : mode == 1 ? 75 : 45));
      step(ins, $urandom_range(0, 20), $urandom_range(0, 4095), rem, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
